bdos_console: RTL
=================

BDOS_CONSOLE -- requirements
Module: bdos_console

Interface
REQ-001 SHALL have parameter TRAP_ADDR, default 16'h0005: the BDOS entry address that triggers a trap.
REQ-002 SHALL have parameter TERM, default 8'h24 ('$'): the string terminator for function 9.
REQ-003 SHALL have parameter MAX_LEN, default 4096: the maximum number of characters emitted per function-9 call.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 m1_valid  in  1  high for one cycle when the CPU is at opcode fetch (M1, T-state 0).
REQ-007 pc  in  16  program counter, valid while m1_valid is high.
REQ-008 reg_c  in  8  CPU register C (BDOS function number).
REQ-009 reg_de  in  16  CPU register pair DE.
REQ-010 mem_rd  out  1  memory read strobe.
REQ-011 mem_addr  out  16  memory read address.
REQ-012 mem_rdata  in  8  memory read data, valid exactly 1 cycle after the mem_rd cycle.
REQ-013 tx_data  out  8  output character.
REQ-014 tx_valid  out  1  character available to the downstream sink.
REQ-015 tx_ready  in  1  downstream sink accepts a character.
REQ-016 cpu_hold  out  1  stalls the CPU while a call is being serviced.
REQ-017 done  out  1  one-cycle pulse when a call completes.
REQ-018 bad_call  out  1  one-cycle pulse on an unsupported function number.
REQ-019 bad_fn  out  8  C value of the last unsupported call.
REQ-020 overflow  out  1  sticky flag: a string reached MAX_LEN characters without a terminator.

Function
REQ-021 Trap SHALL fire in IDLE when m1_valid=1 and pc==TRAP_ADDR; SHALL latch fn=reg_c, ptr=reg_de, e=reg_de[7:0], count=0 on that edge.
REQ-022 m1_valid SHALL be ignored in every state other than IDLE.
REQ-023 FSM states SHALL be IDLE, RD, WAIT, EMIT, DONE.
REQ-024 Trap with fn=2: go to EMIT with tx_data=e.
REQ-025 Trap with fn=9: go to RD.
REQ-026 Trap with any other fn: pulse bad_call next cycle; set bad_fn=fn; stay IDLE; no hold, no tx.
REQ-027 RD (1 cycle): mem_rd=1, mem_addr=ptr, then go to WAIT; mem_rd SHALL be 0 in all other states.
REQ-028 WAIT: if mem_rdata==TERM go to DONE (terminator not emitted); otherwise tx_data<=mem_rdata and go to EMIT.
REQ-029 EMIT: tx_valid=1; tx_data SHALL be held stable until the handshake cycle (tx_valid&tx_ready).
REQ-030 On handshake: fn=2 -> DONE; fn=9 -> ptr+1 (16-bit wrap, FFFF->0000), count+1, then go to DONE with overflow<=1 if count+1==MAX_LEN, otherwise go to RD.
REQ-031 DONE (1 cycle): done=1, then go to IDLE.
REQ-032 cpu_hold SHALL be combinational: (state!=IDLE) | (valid trap of fn 2 or 9 in IDLE); cpu_hold SHALL be low during DONE's successor IDLE cycle.
REQ-033 Per-character throughput with tx_ready tied high SHALL be 3 cycles (RD, WAIT, EMIT).
REQ-034 overflow SHALL clear only on reset.

Reset
REQ-035 rst=0 SHALL immediately force state=IDLE and mem_rd, tx_valid, cpu_hold, done, bad_call, overflow=0, bad_fn=0, tx_data=0, mem_addr=0, regardless of the clock.
REQ-036 Reset mid-call SHALL abandon the call with no further reads or tx beats; the first trap after release SHALL be serviced normally.

Verification
REQ-037 fn2, E=0x41, tx_ready=1 -> one tx beat 0x41, done pulse one cycle later, cpu_hold low afterwards, no mem_rd.
REQ-038 fn9, DE=0x0200, mem[0200..0202]="OK$" -> reads at 0200, 0201, 0202; beats 0x4F, 0x4B; no 0x24 beat; one done pulse.
REQ-039 fn9 with tx_ready=0 for 5 cycles on the first char -> tx_valid held high, tx_data stable, no mem_rd, cpu_hold high throughout.
REQ-040 C=0x07 at trap -> bad_call pulse, bad_fn=0x07, cpu_hold never high, no tx.
REQ-041 fn9, DE=0xFFFE, mem FFFE='A', FFFF='B', 0000='$' -> reads at FFFE, FFFF, 0000; beats 0x41, 0x42.
REQ-042 MAX_LEN=4 with an unterminated string -> exactly 4 beats, overflow=1, done pulse; then rst=0 mid-string on a second call -> all outputs 0 at once.

Source files
------------

// File: rtl/bdos_console.sv
// BDOS console trap: services CP/M console calls (function 2 = write the
// character in E, function 9 = write the string at DE up to TERM) by watching
// opcode fetches at the BDOS entry address and stalling the CPU meanwhile.
module bdos_console #(
  parameter logic [15:0] TRAP_ADDR = 16'h0005,
  parameter logic [7:0]  TERM      = 8'h24,
  parameter int unsigned MAX_LEN   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m1_valid,
  input  logic [15:0] pc,
  input  logic [7:0]  reg_c,
  input  logic [15:0] reg_de,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_hold,
  output logic        done,
  output logic        bad_call,
  output logic [7:0]  bad_fn,
  output logic        overflow
);

  // Counter is wide enough to hold MAX_LEN itself, the value that ends a string
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_fn;
  logic [15:0]   r_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_tx_data;
  logic          r_bad_call;
  logic [7:0]    r_bad_fn;
  logic          r_overflow;

  logic          w_trap;
  logic          w_req_char;
  logic          w_req_str;
  logic          w_is_str;
  logic          w_is_term;
  logic [CW-1:0] w_count_inc;
  logic          w_last;

  assign w_trap      = (r_state == S_IDLE) && m1_valid && (pc == TRAP_ADDR);
  assign w_req_char  = (reg_c == 8'h02);
  assign w_req_str   = (reg_c == 8'h09);
  assign w_is_str    = (r_fn == 8'h09);
  assign w_is_term   = (mem_rdata == TERM);
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (w_count_inc == MAX_CNT);

  assign mem_addr = r_ptr;
  assign tx_data  = r_tx_data;
  assign bad_call = r_bad_call;
  assign bad_fn   = r_bad_fn;
  assign overflow = r_overflow;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and per-state strobes; hold asserts in the trap cycle itself
  always_comb begin
    w_next   = r_state;
    mem_rd   = 1'b0;
    tx_valid = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_hold = w_trap && (w_req_char || w_req_str);
        if (w_trap && w_req_char) begin
          w_next = S_EMIT;
        end else if (w_trap && w_req_str) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        cpu_hold = 1'b1;
        mem_rd   = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        cpu_hold = 1'b1;
        w_next   = w_is_term ? S_DONE : S_EMIT;
      end
      S_EMIT: begin
        cpu_hold = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (w_is_str && !w_last) begin
            w_next = S_RD;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        cpu_hold = 1'b1;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Call context, output character, and the bad-call / overflow reporting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fn       <= 8'h00;
      r_ptr      <= 16'h0000;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_bad_call <= 1'b0;
      r_bad_fn   <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_bad_call <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            r_fn    <= reg_c;
            r_ptr   <= reg_de;
            r_count <= '0;
            if (w_req_char) begin
              r_tx_data <= reg_de[7:0];
            end
            if (!w_req_char && !w_req_str) begin
              r_bad_call <= 1'b1;
              r_bad_fn   <= reg_c;
            end
          end
        end
        S_WAIT: begin
          if (!w_is_term) begin
            r_tx_data <= mem_rdata;
          end
        end
        S_EMIT: begin
          if (tx_ready && w_is_str) begin
            r_ptr   <= r_ptr + 16'h0001;
            r_count <= w_count_inc;
            if (w_last) begin
              r_overflow <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
